// File: rtl/moving_average_filter.sv
// Streaming boxcar averager over the last 2**LOG2_DEPTH samples with valid/ready handshakes.
// Optional MAVG_ROUND_EN selects round-half-up instead of truncating division.
module moving_average_filter #(
   parameter int DATA_W     = 32,
   parameter int LOG2_DEPTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_W-1:0]     in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_W-1:0]     out_data,
   output logic [LOG2_DEPTH:0]   fill_count,
   output logic                  window_full
);

   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SUM_W = DATA_W + LOG2_DEPTH;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ACCUM = 2'd1;
   localparam logic [1:0] OUT   = 2'd2;

   localparam logic [LOG2_DEPTH:0] FULL_COUNT = {1'b1, {LOG2_DEPTH{1'b0}}};

   logic [1:0]              state;
   logic [DATA_W-1:0]       sample;
   logic [SUM_W-1:0]        sum;
   logic [LOG2_DEPTH-1:0]   wr_ptr;
   logic [DATA_W-1:0]       buffer [DEPTH];

   logic [SUM_W-1:0]        sum_next;
   logic [SUM_W-1:0]        rounded_sum;
   logic [DATA_W-1:0]       avg;
   logic [LOG2_DEPTH:0]     fill_next;

   // The evicted entry is always part of sum, so the subtraction cannot underflow.
   always_comb begin
      sum_next = sum - SUM_W'(buffer[wr_ptr]) + SUM_W'(sample);
`ifdef MAVG_ROUND_EN
      rounded_sum = sum_next + SUM_W'(DEPTH / 2);
`else
      rounded_sum = sum_next;
`endif
      avg       = DATA_W'(rounded_sum >> LOG2_DEPTH);
      fill_next = (fill_count == FULL_COUNT) ? fill_count : fill_count + (LOG2_DEPTH+1)'(1);
   end

   assign in_ready = (state == IDLE) && !clear;

   // Clear shares the reset path so a flush drops any in-flight result.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state       <= IDLE;
         sample      <= '0;
         sum         <= '0;
         wr_ptr      <= '0;
         fill_count  <= '0;
         window_full <= 1'b0;
         out_data    <= '0;
         out_valid   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            buffer[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sample <= in_data;
                  state  <= ACCUM;
               end
            end
            ACCUM: begin
               sum            <= sum_next;
               buffer[wr_ptr] <= sample;
               wr_ptr         <= wr_ptr + LOG2_DEPTH'(1);
               fill_count     <= fill_next;
               window_full    <= (fill_next == FULL_COUNT);
               out_data       <= avg;
               out_valid      <= 1'b1;
               state          <= OUT;
            end
            OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_moving_average_filter.sv
// Self-checking bench for moving_average_filter: queue-based window model plus directed pins.
// Honours MAVG_ROUND_EN to select the rounding expectation.
module tb_moving_average_filter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic [6:0]  fill_count;
   logic        window_full;

   logic        s_clear = 1'b0;
   logic        s_in_valid = 1'b0;
   logic        s_in_ready;
   logic [7:0]  s_in_data = 8'd0;
   logic        s_out_valid;
   logic [7:0]  s_out_data;
   logic [2:0]  s_fill_count;
   logic        s_window_full;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] win [$];
   logic [31:0] exp_out = 32'd0;
   int          exp_fill = 0;
   bit          pending = 1'b0;
   bit          checking = 1'b0;

   always #5 clk = ~clk;

   moving_average_filter dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .fill_count(fill_count), .window_full(window_full)
   );

   moving_average_filter #(.DATA_W(8), .LOG2_DEPTH(2)) dut_small (
      .clk(clk), .rst(rst), .clear(s_clear), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
      .fill_count(s_fill_count), .window_full(s_window_full)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endtask

   // Average of the last 64 samples, empty slots counting as zero.
   function automatic logic [31:0] model_avg();
      longint unsigned s = 0;
      foreach (win[i]) s += win[i];
`ifdef MAVG_ROUND_EN
      s += 32;
`endif
      return 32'(s >> 6);
   endfunction

   function automatic void model_reset();
      win.delete();
      exp_fill = 0;
      pending  = 1'b0;
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         check("ready_valid_exclusive", 64'(in_ready && out_valid), 64'd0);
         if (out_valid) check("out_data", 64'(out_data), 64'(exp_out));
         if (!pending || out_valid) begin
            check("fill_count", 64'(fill_count), 64'(exp_fill));
            check("window_full", 64'(window_full), 64'(exp_fill == 64));
         end
      end
   end

   task automatic send(input logic [31:0] d, input int stall, output logic [31:0] got);
      int t = 0;
      while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
      check("in_ready_before_send", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      in_data   = d;
      out_ready = (stall == 0);
      @(posedge clk);
      win.push_back(d);
      if (win.size() > 64) void'(win.pop_front());
      exp_out  = model_avg();
      exp_fill = win.size();
      pending  = 1'b1;
      #1;
      in_valid = 1'b0;
      in_data  = $urandom;
      check("accum_no_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      check("latency_valid", 64'(out_valid), 64'd1);
      got = out_data;
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         check("stall_valid", 64'(out_valid), 64'd1);
         check("stall_hold", 64'(out_data), 64'(got));
         check("stall_in_ready", 64'(in_ready), 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      pending = 1'b0;
      check("after_handshake_valid", 64'(out_valid), 64'd0);
      check("after_handshake_ready", 64'(in_ready), 64'd1);
   endtask

   task automatic do_clear();
      in_valid = 1'b1;
      clear    = 1'b1;
      #1;
      check("clear_blocks_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk);
      model_reset();
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      check("clear_fill", 64'(fill_count), 64'd0);
      check("clear_valid", 64'(out_valid), 64'd0);
   endtask

   task automatic ssend(input logic [7:0] d, output logic [7:0] got);
      int t = 0;
      while (!s_in_ready && t < 20) begin @(posedge clk); #1; t++; end
      s_in_valid = 1'b1;
      s_in_data  = d;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      t = 0;
      while (!s_out_valid && t < 20) begin @(posedge clk); #1; t++; end
      check("small_out_valid", 64'(s_out_valid), 64'd1);
      got = s_out_data;
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      logic [7:0]  sgot;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_out_data", 64'(out_data), 64'd0);
      check("reset_fill", 64'(fill_count), 64'd0);
      check("reset_window_full", 64'(window_full), 64'd0);
      checking = 1'b1;

      for (int k = 1; k <= 64; k++) begin
         send(32'd64, 0, got);
         check("t1_avg", 64'(got), 64'(k));
         if (k == 63) check("t1_not_full_63", 64'(window_full), 64'd0);
      end
      check("t1_full", 64'(window_full), 64'd1);
      check("t1_fill", 64'(fill_count), 64'd64);

      for (int k = 1; k <= 64; k++) begin
         send(32'd0, 0, got);
         check("t2_avg", 64'(got), 64'(64 - k));
      end

      send(32'd640, 5, got);

      in_valid  = 1'b1;
      in_data   = 32'd55;
      out_ready = 1'b1;
      @(posedge clk);
      pending = 1'b1;
      #1 clear = 1'b1;
      #1 check("t4_in_ready_clear", 64'(in_ready), 64'd0);
      @(posedge clk);
      model_reset();
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         check("t4_no_valid", 64'(out_valid), 64'd0);
         check("t4_fill_zero", 64'(fill_count), 64'd0);
      end
      send(32'd100, 0, got);
`ifdef MAVG_ROUND_EN
      check("t4_avg_100", 64'(got), 64'd2);
`else
      check("t4_avg_100", 64'(got), 64'd1);
`endif

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 19) == 0) do_clear();
         else begin
            logic [31:0] d;
            d = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
            send(d, int'($urandom_range(0, 3)), got);
         end
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      do_clear();
      for (int k = 1; k <= 64; k++) send(32'hFFFF_FFFF, 0, got);
      check("t6_max_avg", 64'(got), 64'hFFFF_FFFF);
      check("t6_full", 64'(window_full), 64'd1);

      in_valid  = 1'b1;
      in_data   = 32'd5;
      out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      check("t6_in_out", 64'(out_valid), 64'd1);
      checking = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      model_reset();
      check("t6_rst_valid", 64'(out_valid), 64'd0);
      check("t6_rst_data", 64'(out_data), 64'd0);
      check("t6_rst_fill", 64'(fill_count), 64'd0);
      check("t6_rst_full", 64'(window_full), 64'd0);
      check("t6_rst_ready", 64'(in_ready), 64'd1);
      checking = 1'b1;
      send(32'd64, 0, got);
      check("t6_after_rst_avg", 64'(got), 64'd1);

      ssend(8'd1, sgot);
      check("t5_first", 64'(sgot), 64'd0);
      ssend(8'd1, sgot);
`ifdef MAVG_ROUND_EN
      check("t5_second", 64'(sgot), 64'd1);
`else
      check("t5_second", 64'(sgot), 64'd0);
`endif
      s_clear = 1'b1;
      @(posedge clk); #1;
      s_clear = 1'b0;
      check("t5_clear_fill", 64'(s_fill_count), 64'd0);
      for (int k = 0; k < 3; k++) ssend(8'd3, sgot);
      check("t5_three", 64'(sgot), 64'd2);
      check("t5_fill", 64'(s_fill_count), 64'd3);
      check("t5_not_full", 64'(s_window_full), 64'd0);

      checking = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
